// File: rtl/fetch_if.sv
// fetch_if: IMEM request/ack bus plus decode valid/ready and redirect/flush controls.
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc4_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] flush_pc;
  logic        fetch_err;
  modport master (
    output imem_req, imem_addr, instr_out, pc_out, pc4_out, instr_valid, fetch_err,
    input  imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc, flush, flush_pc
  );
  modport slave (
    input  imem_req, imem_addr, instr_out, pc_out, pc4_out, instr_valid, fetch_err,
    output imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc, flush, flush_pc
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches from IMEM via req/ack and hands words to decode.
// Define FETCH_EXC_EN to add the exc_req port, which flushes to EXC_VEC ahead of flush.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
  input logic      clk,
  input logic      rst_n,
`ifdef FETCH_EXC_EN
  input logic      exc_req,
`endif
  fetch_if.master  bus
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, REQ, VALID, ERR} state_t;
  state_t          state, state_nxt;
  logic [31:0]     pc, pc_nxt, addr, instr, fl_pc;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            discard, disc_nxt, fl;
`ifdef FETCH_EXC_EN
  assign fl    = exc_req | bus.flush;
  assign fl_pc = exc_req ? EXC_VEC : bus.flush_pc;
`else
  wire unused_exc = ^EXC_VEC;
  assign fl    = bus.flush;
  assign fl_pc = bus.flush_pc;
`endif
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    disc_nxt  = discard;
    cnt_nxt   = '0;
    if (state != ERR && fl) begin
      pc_nxt    = {fl_pc[31:2], 2'b00};
      state_nxt = REQ;
      // The outstanding read cannot be retracted, so its word is dropped when it lands.
      disc_nxt  = (state == REQ && !bus.imem_ack) ? 1'b1 : discard;
      cnt_nxt   = (state == REQ && !bus.imem_ack) ? cnt : '0;
    end else begin
      case (state)
        IDLE: state_nxt = REQ;
        REQ: begin
          if (bus.imem_ack) begin
            disc_nxt  = 1'b0;
            state_nxt = discard ? REQ : VALID;
          end else if (cnt == CW'(TIMEOUT - 1)) state_nxt = ERR;
          else cnt_nxt = cnt + CW'(1);
        end
        VALID: if (bus.instr_ready) begin
          pc_nxt    = bus.redirect_valid ? {bus.redirect_pc[31:2], 2'b00} : pc + 32'd4;
          state_nxt = REQ;
        end
        default: state_nxt = ERR;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      addr    <= RESET_PC;
      instr   <= '0;
      cnt     <= '0;
      discard <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      cnt     <= cnt_nxt;
      discard <= disc_nxt;
      addr    <= (state == REQ && !bus.imem_ack) ? addr : pc_nxt;
      if (state == REQ && bus.imem_ack && !discard && !fl) instr <= bus.imem_rdata;
    end
  end
  assign bus.imem_req    = state == REQ;
  assign bus.imem_addr   = addr;
  assign bus.instr_valid = state == VALID;
  assign bus.instr_out   = instr;
  assign bus.pc_out      = pc;
  assign bus.pc4_out     = pc + 32'd4;
  assign bus.fetch_err   = state == ERR;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vectors with hand-computed expectations for fetch_sequencer.
module tb_fetch_sequencer;
  logic clk = 0;
  logic rst_n = 0;
  int   errors = 0;
  int   checks = 0;
  fetch_if f();
`ifdef FETCH_EXC_EN
  logic exc_req = 0;
`endif
  fetch_sequencer dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef FETCH_EXC_EN
    .exc_req(exc_req),
`endif
    .bus(f.master)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] d);
    chk("req", 32'(f.imem_req), 32'd1);
    chk("addr", f.imem_addr, a);
    f.imem_ack = 1; f.imem_rdata = d;
    tick();
    f.imem_ack = 0;
    chk("valid", 32'(f.instr_valid), 32'd1);
    chk("req_off", 32'(f.imem_req), 32'd0);
    chk("instr", f.instr_out, d);
    chk("pc", f.pc_out, a);
    chk("pc4", f.pc4_out, a + 32'd4);
  endtask
  task automatic accept(input logic rv, input logic [31:0] rpc);
    f.instr_ready = 1; f.redirect_valid = rv; f.redirect_pc = rpc;
    tick();
    f.instr_ready = 0; f.redirect_valid = 0;
    chk("valid_clr", 32'(f.instr_valid), 32'd0);
  endtask
  initial begin
    f.imem_ack = 0; f.imem_rdata = 0; f.instr_ready = 0;
    f.redirect_valid = 0; f.redirect_pc = 0; f.flush = 0; f.flush_pc = 0;
    tick(); tick();
    chk("rst_req", 32'(f.imem_req), 32'd0);
    chk("rst_addr", f.imem_addr, 32'h3000);
    chk("rst_valid", 32'(f.instr_valid), 32'd0);
    chk("rst_instr", f.instr_out, 32'd0);
    chk("rst_pc", f.pc_out, 32'h3000);
    chk("rst_err", 32'(f.fetch_err), 32'd0);
    rst_n = 1;
    tick();
    // sequential fetch
    do_fetch(32'h3000, 32'hA000_0000); accept(0, 0);
    do_fetch(32'h3004, 32'hA000_0004); accept(0, 0);
    do_fetch(32'h3008, 32'hA000_0008); accept(0, 0);
    // redirect with misaligned target
    do_fetch(32'h300C, 32'hA000_000C); accept(1, 32'h3103);
    do_fetch(32'h3100, 32'hA000_0100); accept(0, 0);
    // flush while request outstanding, late ack is dropped
    f.flush = 1; f.flush_pc = 32'h3200;
    tick();
    f.flush = 0;
    chk("fl_req", 32'(f.imem_req), 32'd1);
    chk("fl_hold", f.imem_addr, 32'h3104);
    tick(); tick();
    f.imem_ack = 1; f.imem_rdata = 32'hDEAD;
    tick();
    f.imem_ack = 0;
    chk("fl_nvalid", 32'(f.instr_valid), 32'd0);
    chk("fl_addr", f.imem_addr, 32'h3200);
    do_fetch(32'h3200, 32'hB000_0000);
    // stall
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("st_valid", 32'(f.instr_valid), 32'd1);
      chk("st_instr", f.instr_out, 32'hB000_0000);
      chk("st_pc", f.pc_out, 32'h3200);
      chk("st_req", 32'(f.imem_req), 32'd0);
    end
    accept(0, 0);
    // flush coinciding with ack: word dropped, no pending discard
    f.flush = 1; f.flush_pc = 32'h3302; f.imem_ack = 1; f.imem_rdata = 32'hDEAD;
    tick();
    f.flush = 0; f.imem_ack = 0;
    chk("fa_nvalid", 32'(f.instr_valid), 32'd0);
    do_fetch(32'h3300, 32'hC000_0000);
    // wrap at top of address space
    accept(1, 32'hFFFF_FFFE);
    do_fetch(32'hFFFF_FFFC, 32'hD000_0000);
    chk("wrap_pc4", f.pc4_out, 32'h0);
    accept(0, 0);
    chk("wrap_addr", f.imem_addr, 32'h0);
`ifdef FETCH_EXC_EN
    exc_req = 1; f.flush = 1; f.flush_pc = 32'h3200;
    tick();
    exc_req = 0; f.flush = 0;
    chk("exc_hold", f.imem_addr, 32'h0);
    f.imem_ack = 1; f.imem_rdata = 32'hDEAD;
    tick();
    f.imem_ack = 0;
    chk("exc_nvalid", 32'(f.instr_valid), 32'd0);
    do_fetch(32'h4180, 32'hE000_0000);
    accept(0, 0);
`endif
    // timeout: req stays up for TIMEOUT cycles, then sticky error
    for (int i = 0; i < 16; i++) begin
      chk("to_req", 32'(f.imem_req), 32'd1);
      chk("to_noerr", 32'(f.fetch_err), 32'd0);
      tick();
    end
    chk("to_err", 32'(f.fetch_err), 32'd1);
    chk("to_req_off", 32'(f.imem_req), 32'd0);
    f.imem_ack = 1; f.flush = 1;
    tick(); tick();
    f.imem_ack = 0; f.flush = 0;
    chk("err_sticky", 32'(f.fetch_err), 32'd1);
    #2 rst_n = 0;
    #1;
    chk("arst_err", 32'(f.fetch_err), 32'd0);
    chk("arst_addr", f.imem_addr, 32'h3000);
    chk("arst_req", 32'(f.imem_req), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
